mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one memory port between IFU and LSU,
//            with a single outstanding transaction (IDLE -> ISSUE -> WAIT).
// Revision : 1.0
// ============================================================================
module mem_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_ifu_req_valid,
    output logic        o_ifu_req_ready,
    input  logic [31:0] i_ifu_addr,
    output logic        o_ifu_rsp_valid,
    output logic [31:0] o_ifu_rdata,

    input  logic        i_lsu_req_valid,
    output logic        o_lsu_req_ready,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_lsu_wen,
    input  logic [31:0] i_lsu_wdata,
    input  logic [7:0]  i_lsu_wmask,
    output logic        o_lsu_rsp_valid,
    output logic [31:0] o_lsu_rdata,

    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [7:0]  o_mem_wmask,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rdata,

    output logic        o_busy,
    output logic        o_owner,
    output logic        o_rsp_err
);

    localparam logic [7:0] c_IFU_WMASK = 8'h0F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rr_last;
    logic        r_owner;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [7:0]  r_wmask;
    logic        r_rsp_err;

    logic w_idle;
    logic w_issue;
    logic w_wait;
    logic w_grant_ifu;
    logic w_grant_lsu;

    assign w_idle  = (r_state == S_IDLE);
    assign w_issue = (r_state == S_ISSUE);
    assign w_wait  = (r_state == S_WAIT);

    // On a tie the requester that did not complete last wins.
    assign w_grant_ifu = i_ifu_req_valid & (~i_lsu_req_valid | r_rr_last);
    assign w_grant_lsu = i_lsu_req_valid & (~i_ifu_req_valid | ~r_rr_last);

    // Readiness is held low while reset is asserted even though state is IDLE.
    assign o_ifu_req_ready = i_rst_n & w_idle & w_grant_ifu;
    assign o_lsu_req_ready = i_rst_n & w_idle & w_grant_lsu;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_addr    <= 32'd0;
            r_wen     <= 1'b0;
            r_wdata   <= 32'd0;
            r_wmask   <= 8'd0;
            r_rsp_err <= 1'b0;
        end else begin
            if (i_mem_rsp_valid && !w_wait) begin
                r_rsp_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (o_ifu_req_ready) begin
                        r_owner <= 1'b0;
                        r_addr  <= i_ifu_addr;
                        r_wen   <= 1'b0;
                        r_wdata <= 32'd0;
                        r_wmask <= c_IFU_WMASK;
                        r_state <= S_ISSUE;
                    end else if (o_lsu_req_ready) begin
                        r_owner <= 1'b1;
                        r_addr  <= i_lsu_addr;
                        r_wen   <= i_lsu_wen;
                        r_wdata <= i_lsu_wdata;
                        r_wmask <= i_lsu_wmask;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rsp_valid) begin
                        r_rr_last <= r_owner;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req_valid = w_issue;
    assign o_mem_addr      = r_addr;
    assign o_mem_wen       = w_issue & r_wen;
    assign o_mem_wdata     = r_wdata;
    assign o_mem_wmask     = r_wmask;

    // Response routing is combinational so the pulse lands in the WAIT cycle.
    assign o_ifu_rsp_valid = w_wait & i_mem_rsp_valid & ~r_owner;
    assign o_lsu_rsp_valid = w_wait & i_mem_rsp_valid &  r_owner;
    assign o_ifu_rdata     = i_mem_rdata;
    assign o_lsu_rdata     = i_mem_rdata;

    assign o_busy    = ~w_idle;
    assign o_owner   = r_owner;
    assign o_rsp_err = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ifu_req_valid (ifu_req_valid),
        .o_ifu_req_ready (ifu_req_ready),
        .i_ifu_addr      (ifu_addr),
        .o_ifu_rsp_valid (ifu_rsp_valid),
        .o_ifu_rdata     (ifu_rdata),
        .i_lsu_req_valid (lsu_req_valid),
        .o_lsu_req_ready (lsu_req_ready),
        .i_lsu_addr      (lsu_addr),
        .i_lsu_wen       (lsu_wen),
        .i_lsu_wdata     (lsu_wdata),
        .i_lsu_wmask     (lsu_wmask),
        .o_lsu_rsp_valid (lsu_rsp_valid),
        .o_lsu_rdata     (lsu_rdata),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_wen       (mem_wen),
        .o_mem_wdata     (mem_wdata),
        .o_mem_wmask     (mem_wmask),
        .i_mem_rsp_valid (mem_rsp_valid),
        .i_mem_rdata     (mem_rdata),
        .o_busy          (busy),
        .o_owner         (owner),
        .o_rsp_err       (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with mem_req_ready high at issue and the
    // response in the first WAIT cycle; requester inputs are set by the caller.
    task automatic run_txn(input logic exp_owner, input logic [31:0] exp_addr,
                           input logic exp_wen, input logic [7:0] exp_wmask,
                           input logic [31:0] rdata);
        #1;
        chk("ifu_ready_grant", {31'd0, ifu_req_ready}, {31'd0, ~exp_owner});
        chk("lsu_ready_grant", {31'd0, lsu_req_ready}, {31'd0, exp_owner});
        tick();
        chk("issue_busy", {31'd0, busy}, 32'd1);
        chk("issue_owner", {31'd0, owner}, {31'd0, exp_owner});
        chk("issue_mem_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("issue_addr", mem_addr, exp_addr);
        chk("issue_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
        chk("issue_wmask", {24'd0, mem_wmask}, {24'd0, exp_wmask});
        chk("issue_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("wait_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("wait_no_pulse", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        #1;
        chk("rsp_ifu_valid", {31'd0, ifu_rsp_valid}, {31'd0, ~exp_owner});
        chk("rsp_lsu_valid", {31'd0, lsu_rsp_valid}, {31'd0, exp_owner});
        chk("rsp_rdata", exp_owner ? lsu_rdata : ifu_rdata, rdata);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("done_idle", {31'd0, busy}, 32'd0);
        chk("done_no_pulse", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0200;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'd0;
        lsu_wmask     = 8'hFF;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;

        // Reset state with both requesters pending
        tick();
        tick();
        chk("rst_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_rsp_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wmask", {24'd0, mem_wmask}, 32'd0);

        // Contention right after reset: IFU first, then LSU, IFU, LSU
        rst_n = 1'b1;
        run_txn(1'b0, 32'h8000_0000, 1'b0, 8'h0F, 32'h0010_0073);
        run_txn(1'b1, 32'h8000_0200, 1'b0, 8'hFF, 32'h1234_5678);
        run_txn(1'b0, 32'h8000_0000, 1'b0, 8'h0F, 32'hCAFE_0001);
        run_txn(1'b1, 32'h8000_0200, 1'b0, 8'hFF, 32'hCAFE_0002);

        // LSU store with a stalled memory port; later input changes are ignored
        ifu_req_valid = 1'b0;
        lsu_addr      = 32'h8000_0100;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 8'h01;
        #1;
        chk("st_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 8'hFF;
        ifu_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("st_mem_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("st_addr", mem_addr, 32'h8000_0100);
            chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_wmask", {24'd0, mem_wmask}, 32'h01);
            chk("st_wen", {31'd0, mem_wen}, 32'd1);
            chk("st_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("st_wait_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
        chk("st_wait_wen", {31'd0, mem_wen}, 32'd0);
        mem_rsp_valid = 1'b1;
        ifu_req_valid = 1'b0;
        #1;
        chk("st_lsu_rsp", {31'd0, lsu_rsp_valid}, 32'd1);
        chk("st_ifu_rsp", {31'd0, ifu_rsp_valid}, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("st_done_busy", {31'd0, busy}, 32'd0);
        chk("st_done_pulse", {31'd0, lsu_rsp_valid}, 32'd0);

        // Stray response while idle
        mem_rsp_valid = 1'b1;
        #1;
        chk("stray_no_pulse", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("stray_err", {31'd0, rsp_err}, 32'd1);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("stray_err_sticky", {31'd0, rsp_err}, 32'd1);

        // Reset asserted in WAIT aborts the LSU read without a pulse
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_0300;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("abort_in_wait", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_no_pulse", {31'd0, lsu_rsp_valid}, 32'd0);
        chk("abort_err_clr", {31'd0, rsp_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        run_txn(1'b0, 32'h8000_0040, 1'b0, 8'h0F, 32'h0000_0013);
        ifu_req_valid = 1'b0;
        chk("post_abort_err", {31'd0, rsp_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
